sram_fifo_ctrl: RTL and testbench

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

---
 rtl/sram_fifo_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_sram_fifo_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller keeping its words in an external asynchronous SRAM, two-cycle strobes per access.
// Optional sticky ovf/udf error flags are built when SRAM_FIFO_ERR_FLAGS_EN is defined.
module sram_fifo_ctrl #(
    parameter int DW        = 8,
    parameter int AW        = 11,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          fifowr,
    input  logic          fiford,
    output logic [DW-1:0] out_data,
    output logic          nfull,
    output logic          nempty,
    output logic          naf,
    output logic [AW:0]   count,
    output logic [AW-1:0] address,
    inout  wire  [DW-1:0] sram_data,
    output logic          rd,
    output logic          wr
`ifdef SRAM_FIFO_ERR_FLAGS_EN
    ,
    output logic          ovf,
    output logic          udf
`endif
);

    typedef enum logic [2:0] {IDLE, WR1, WR2, RD1, RD2} state_t;

    localparam logic [AW:0]   C_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_AF_LVL = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [AW:0]   C_CNT1   = (AW+1)'(1);
    localparam logic [AW-1:0] C_LAST   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] C_PTR1   = AW'(1);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_fifowr_q;
    logic          r_fiford_q;
    logic          r_armed;
    logic          r_wr_pend;
    logic          r_rd_pend;
    logic [DW-1:0] r_wdata_lat;
    logic [DW-1:0] r_wdout;
    logic          r_drive;
    logic [AW-1:0] r_addr;
    logic          r_rd_n;
    logic          r_wr_n;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [DW-1:0] r_out_data;
    logic          r_nfull;
    logic          r_nempty;
    logic          r_naf;

    logic          w_wr_fall;
    logic          w_rd_fall;
    logic          w_full;
    logic          w_empty;
    logic [AW-1:0] w_wptr_inc;
    logic [AW-1:0] w_rptr_inc;
    logic [AW-1:0] w_addr_d;
    logic          w_rd_d;
    logic          w_wr_d;
    logic          w_drive_d;
    logic          w_clr_wr;
    logic          w_clr_rd;
    logic          w_load_wdout;

    // r_armed masks the first clock after reset so a strobe held low through release is ignored.
    assign w_wr_fall  = r_armed & r_fifowr_q & ~fifowr;
    assign w_rd_fall  = r_armed & r_fiford_q & ~fiford;
    assign w_full     = (r_count == C_DEPTH);
    assign w_empty    = (r_count == '0);
    assign w_wptr_inc = (r_wptr == C_LAST) ? '0 : r_wptr + C_PTR1;
    assign w_rptr_inc = (r_rptr == C_LAST) ? '0 : r_rptr + C_PTR1;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        w_addr_d     = r_addr;
        w_rd_d       = 1'b1;
        w_wr_d       = 1'b1;
        w_drive_d    = 1'b0;
        w_clr_wr     = 1'b0;
        w_clr_rd     = 1'b0;
        w_load_wdout = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_rd_pend) begin
                    w_clr_rd = 1'b1;
                    if (!w_empty) begin
                        w_next_state = RD1;
                        w_addr_d     = r_rptr;
                        w_rd_d       = 1'b0;
                    end
                end else if (r_wr_pend) begin
                    w_clr_wr = 1'b1;
                    if (!w_full) begin
                        w_next_state = WR1;
                        w_addr_d     = r_wptr;
                        w_wr_d       = 1'b0;
                        w_drive_d    = 1'b1;
                        w_load_wdout = 1'b1;
                    end
                end
            end
            WR1: begin
                w_next_state = WR2;
                w_drive_d    = 1'b1;
            end
            WR2:     w_next_state = IDLE;
            RD1:     w_next_state = RD2;
            RD2:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fifowr_q  <= 1'b1;
            r_fiford_q  <= 1'b1;
            r_armed     <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_wdata_lat <= '0;
            r_wdout     <= '0;
            r_drive     <= 1'b0;
            r_addr      <= '0;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_nfull     <= 1'b1;
            r_nempty    <= 1'b0;
            r_naf       <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_fifowr_q <= fifowr;
            r_fiford_q <= fiford;
            r_armed    <= 1'b1;
            // A new falling edge wins over the clear of the request being serviced.
            r_wr_pend  <= w_wr_fall | (r_wr_pend & ~w_clr_wr);
            r_rd_pend  <= w_rd_fall | (r_rd_pend & ~w_clr_rd);
            if (w_wr_fall)    r_wdata_lat <= in_data;
            if (w_load_wdout) r_wdout     <= r_wdata_lat;
            r_drive <= w_drive_d;
            r_addr  <= w_addr_d;
            r_rd_n  <= w_rd_d;
            r_wr_n  <= w_wr_d;
            // Capture while rd is still low so the SRAM is guaranteed to be driving.
            if (r_state == RD1) r_out_data <= sram_data;
            if (r_state == WR2) begin
                r_wptr  <= w_wptr_inc;
                r_count <= r_count + C_CNT1;
            end else if (r_state == RD2) begin
                r_rptr  <= w_rptr_inc;
                r_count <= r_count - C_CNT1;
            end
            r_nfull  <= (r_count != C_DEPTH);
            r_nempty <= (r_count != '0);
            r_naf    <= (r_count < C_AF_LVL);
        end
    end

`ifdef SRAM_FIFO_ERR_FLAGS_EN
    logic r_ovf;
    logic r_udf;
    logic w_drop_wr;
    logic w_drop_rd;

    assign w_drop_rd = (r_state == IDLE) & r_rd_pend & w_empty;
    assign w_drop_wr = (r_state == IDLE) & ~r_rd_pend & r_wr_pend & w_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | w_drop_wr;
            r_udf <= r_udf | w_drop_rd;
        end
    end

    assign ovf = r_ovf;
    assign udf = r_udf;
`endif

    assign sram_data = r_drive ? r_wdout : {DW{1'bz}};
    assign out_data  = r_out_data;
    assign nfull     = r_nfull;
    assign nempty    = r_nempty;
    assign naf       = r_naf;
    assign count     = r_count;
    assign address   = r_addr;
    assign rd        = r_rd_n;
    assign wr        = r_wr_n;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl: SRAM model, scoreboard of written words, flag/count model.
// Build with SRAM_FIFO_ERR_FLAGS_EN defined to also check the sticky ovf/udf flags.
module tb_sram_fifo_ctrl;

    localparam int DW        = 8;
    localparam int AW        = 11;
    localparam int DEPTH     = 8;
    localparam int AF_MARGIN = 2;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          fifowr;
    logic          fiford;
    logic [DW-1:0] out_data;
    logic          nfull;
    logic          nempty;
    logic          naf;
    logic [AW:0]   count;
    logic [AW-1:0] address;
    wire  [DW-1:0] sram_data;
    logic          rd;
    logic          wr;
`ifdef SRAM_FIFO_ERR_FLAGS_EN
    logic          ovf;
    logic          udf;
`endif

    sram_fifo_ctrl #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .fifowr   (fifowr),
        .fiford   (fiford),
        .out_data (out_data),
        .nfull    (nfull),
        .nempty   (nempty),
        .naf      (naf),
        .count    (count),
        .address  (address),
        .sram_data(sram_data),
        .rd       (rd),
        .wr       (wr)
`ifdef SRAM_FIFO_ERR_FLAGS_EN
        ,
        .ovf      (ovf),
        .udf      (udf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM model: drives the bus while rd is low, stores while wr is low.
    logic [DW-1:0] mem [0:(2**AW)-1];
    assign sram_data = (rd == 1'b0) ? mem[address] : {DW{1'bz}};

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] sb[$];
    int            exp_count = 0;
    bit            exp_ovf = 1'b0;
    bit            exp_udf = 1'b0;
    logic [DW-1:0] last_rd = '0;
    int            m_wptr = 0;
    int            m_rptr = 0;
    int            wr_pulses = 0;
    int            rd_pulses = 0;
    int            wr_cyc = 0;
    int            rd_cyc = 0;
    int            cyc = 0;
    bit            rd_cmp_due = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor on the falling edge: SRAM writes, address checks, read-data scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            m_wptr     <= 0;
            m_rptr     <= 0;
            rd_cmp_due <= 1'b0;
        end else begin
            if (rd_cmp_due) begin
                rd_cmp_due <= 1'b0;
                check("rd_has_expect", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    check("rd_data", out_data, sb[0]);
                    last_rd <= sb[0];
                    void'(sb.pop_front());
                end
            end
            if (wr === 1'b0) begin
                mem[address] <= sram_data;
                wr_pulses    <= wr_pulses + 1;
                wr_cyc       <= cyc;
                check("wr_addr", address, m_wptr);
                m_wptr <= (m_wptr == DEPTH - 1) ? 0 : m_wptr + 1;
            end
            if (rd === 1'b0) begin
                rd_pulses  <= rd_pulses + 1;
                rd_cyc     <= cyc;
                rd_cmp_due <= 1'b1;
                check("rd_addr", address, m_rptr);
                m_rptr <= (m_rptr == DEPTH - 1) ? 0 : m_rptr + 1;
            end
        end
    end

    task automatic check_flags(input string tag);
        check({tag, "_count"},  count,  exp_count);
        check({tag, "_nfull"},  nfull,  32'(exp_count != DEPTH));
        check({tag, "_nempty"}, nempty, 32'(exp_count != 0));
        check({tag, "_naf"},    naf,    32'(exp_count < DEPTH - AF_MARGIN));
`ifdef SRAM_FIFO_ERR_FLAGS_EN
        check({tag, "_ovf"},    ovf,    exp_ovf);
        check({tag, "_udf"},    udf,    exp_udf);
`endif
    endtask

    task automatic do_write(input logic [DW-1:0] d);
        int wp0;
        bit ok;
        wp0 = wr_pulses;
        ok  = (exp_count < DEPTH);
        @(negedge clk);
        in_data = d;
        fifowr  = 1'b0;
        @(negedge clk);
        fifowr = 1'b1;
        repeat (5) @(negedge clk);
        if (ok) begin
            sb.push_back(d);
            exp_count++;
        end else begin
            exp_ovf = 1'b1;
        end
        check("wr_pulse", wr_pulses - wp0, 32'(ok));
        check_flags("wr");
    endtask

    task automatic do_read();
        int            rp0;
        bit            ok;
        logic [DW-1:0] hold;
        rp0  = rd_pulses;
        ok   = (exp_count > 0);
        hold = last_rd;
        @(negedge clk);
        fiford = 1'b0;
        @(negedge clk);
        fiford = 1'b1;
        repeat (5) @(negedge clk);
        check("rd_pulse", rd_pulses - rp0, 32'(ok));
        if (ok) begin
            exp_count--;
        end else begin
            exp_udf = 1'b1;
            check("rd_hold", out_data, hold);
        end
        check_flags("rd");
    endtask

    initial begin
        int            wp0;
        int            rp0;
        logic [DW-1:0] d;

        // Reset with the write strobe held low through release: must not become a request.
        rst     = 1'b1;
        fifowr  = 1'b0;
        fiford  = 1'b1;
        in_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_flags("reset");
        check("reset_rd",      rd,        1);
        check("reset_wr",      wr,        1);
        check("reset_out",     out_data,  0);
        check("reset_addr",    address,   0);
        check("held_low_wr",   wr_pulses, 0);
        fifowr = 1'b1;
        repeat (2) @(negedge clk);

        // Fill to full, then two writes that must be dropped.
        for (int i = 0; i < DEPTH; i++) do_write(DW'($urandom));
        for (int i = 0; i < 2; i++)     do_write(DW'($urandom));

        // Drain in order, then one read from empty.
        for (int i = 0; i < DEPTH; i++) do_read();
        do_read();

        // Single-word round trips; pointers wrap twice.
        for (int i = 0; i < 2 * DEPTH; i++) begin
            do_write(DW'($urandom));
            do_read();
        end

        // Simultaneous read and write requests at count 3: read goes first.
        for (int i = 0; i < 3; i++) do_write(DW'($urandom));
        d   = DW'($urandom);
        wp0 = wr_pulses;
        rp0 = rd_pulses;
        sb.push_back(d);
        @(negedge clk);
        in_data = d;
        fifowr  = 1'b0;
        fiford  = 1'b0;
        @(negedge clk);
        fifowr = 1'b1;
        fiford = 1'b1;
        repeat (3) @(negedge clk);
        check("both_mid_count", count, 2);
        repeat (3) @(negedge clk);
        check("both_end_count", count, 3);
        check("both_rd_pulse",  rd_pulses - rp0, 1);
        check("both_wr_pulse",  wr_pulses - wp0, 1);
        check("both_rd_first",  32'(rd_cyc < wr_cyc), 1);
        repeat (2) @(negedge clk);
        exp_count = 3;
        check_flags("both");
        for (int i = 0; i < 3; i++) do_read();

        // Reset pulse while the controller is in WR2 aborts the write.
        d   = DW'($urandom);
        wp0 = wr_pulses;
        @(negedge clk);
        in_data = d;
        fifowr  = 1'b0;
        @(negedge clk);
        fifowr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_count",    count, 0);
        check("abort_wr",       wr,    1);
        check("abort_wr_pulse", wr_pulses - wp0, 1);
        sb.delete();
        exp_count = 0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
        last_rd   = '0;
        repeat (2) @(negedge clk);
        check_flags("abort");
        do_read();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
